// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared widths, constants and the buffered fetch entry type.
package instruction_fetch_stage_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int PC_WIDTH = 32;
    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0;
    localparam logic [PC_WIDTH-1:0] PC_INCREMENT = 32'd4;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } fetch_entry_t;

    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: request/response channel between fetch and the instruction cache.
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;
    logic                         icache_request_o;
    logic [PC_WIDTH-1:0]          icache_addr_o;
    logic                         icache_ready_i;
    logic                         icache_data_valid_i;
    logic [INSTRUCTION_WIDTH-1:0] icache_data_i;

    modport master (
        output icache_request_o, icache_addr_o,
        input  icache_ready_i, icache_data_valid_i, icache_data_i
    );
    modport slave (
        input  icache_request_o, icache_addr_o,
        output icache_ready_i, icache_data_valid_i, icache_data_i
    );
endinterface

// File: rtl/instruction_fetch_stage_fifo.sv
// instruction_fifo: synchronous FIFO with clear, holding fetched {pc, instruction} pairs.
module instruction_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: sequential fetch with credit-limited icache requests, in-order
// response buffering, and restart that drops responses still in flight.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    instruction_fetch_stage_if.master     icache,
    input  logic                          stall_i,
    input  logic                          restart_i,
    input  logic [PC_WIDTH-1:0]           restart_pc_i,
    output logic [INSTRUCTION_WIDTH-1:0]  instruction_o,
    output logic [PC_WIDTH-1:0]           pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc, resp_pc, restart_base;
    logic [CW-1:0]       outstanding, stale, fifo_count;
    logic                fifo_empty, fifo_full, accept, stale_hit, live, push, pop;
    fetch_entry_t        fifo_head;

    // Credits cover both in-flight requests and buffered words, so a push can never overflow.
    assign icache.icache_request_o = reset_n && !restart_i && !fifo_full &&
                                     (outstanding + fifo_count < CW'(FIFO_DEPTH));
    assign icache.icache_addr_o    = fetch_pc;
    assign accept       = icache.icache_request_o && icache.icache_ready_i;
    assign stale_hit    = icache.icache_data_valid_i && stale != '0;
    assign live         = icache.icache_data_valid_i && stale == '0;
    assign push         = live && !restart_i;
    assign pop          = !restart_i && !stall_i && !fifo_empty;
    assign restart_base = align_pc(restart_pc_i);

    instruction_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .clear   (restart_i),
        .din     ({resp_pc, icache.icache_data_i}),
        .dout    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            outstanding   <= '0;
            stale         <= '0;
            instruction_o <= NOP_INSTRUCTION;
            pc_o          <= '0;
        end else if (restart_i) begin
            fetch_pc      <= restart_base;
            resp_pc       <= restart_base;
            // A response landing in the restart cycle is already accounted for in stale+outstanding.
            stale         <= stale + outstanding - CW'(icache.icache_data_valid_i);
            outstanding   <= '0;
            instruction_o <= NOP_INSTRUCTION;
            pc_o          <= '0;
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_INCREMENT;
            if (live) resp_pc <= resp_pc + PC_INCREMENT;
            outstanding <= outstanding + CW'(accept) - CW'(live);
            stale       <= stale - CW'(stale_hit);
            if (!stall_i) {pc_o, instruction_o} <= fifo_empty ? {PC_WIDTH'(0), NOP_INSTRUCTION} : fifo_head;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed checks of issue, buffering, stall, restart and wrap,
// against a fixed-latency cache responder whose data word is the bitwise inverse of the address.
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        restart_i = 1'b0;
    logic [31:0] restart_pc_i = '0;
    logic [31:0] instruction_o, pc_o;
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          cyc = 0;
    req_t        q[$];

    instruction_fetch_stage_if ifc ();

    instruction_fetch_stage #(.FIFO_DEPTH(4), .RESET_PC(32'h100)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .icache        (ifc),
        .stall_i       (stall_i),
        .restart_i     (restart_i),
        .restart_pc_i  (restart_pc_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            if (reset_n && ifc.icache_request_o && ifc.icache_ready_i) q.push_back('{ifc.icache_addr_o, cyc + lat});
            cyc = cyc + 1;
        end
    end

    initial begin
        ifc.icache_data_valid_i = 1'b0;
        ifc.icache_data_i = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                ifc.icache_data_valid_i = 1'b0;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                ifc.icache_data_valid_i = 1'b1;
                ifc.icache_data_i = ~q[0].a;
                void'(q.pop_front());
            end else begin
                ifc.icache_data_valid_i = 1'b0;
                ifc.icache_data_i = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_ins"}, instruction_o, ins);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ifc.icache_ready_i = 1'b1;
        step(2);
        chk("rst_req", 32'(ifc.icache_request_o), 32'h0);
        chk("rst_addr", ifc.icache_addr_o, 32'h100);
        chk_out("rst_out", 32'h0, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("c0_req", 32'(ifc.icache_request_o), 32'h1);
        chk("c0_addr", ifc.icache_addr_o, 32'h100);
        step();
        chk("c1_addr", ifc.icache_addr_o, 32'h104);
        step();
        chk("c2_addr", ifc.icache_addr_o, 32'h108);
        chk_out("c2_out", 32'h0, 32'h0);
        step();
        chk_out("c3_out", 32'h100, ~32'h100);
        step();
        chk_out("c4_out", 32'h104, ~32'h104);
        step();
        chk_out("c5_out", 32'h108, ~32'h108);

        reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(ifc.icache_request_o), 32'h0);
        chk("arst_addr", ifc.icache_addr_o, 32'h100);
        chk_out("arst_out", 32'h0, 32'h0);
        step(2);
        reset_n = 1'b1;
        #1;
        step();
        chk("rdy_c1_addr", ifc.icache_addr_o, 32'h104);
        ifc.icache_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rdy_hold_addr", ifc.icache_addr_o, 32'h104);
            chk("rdy_hold_req", 32'(ifc.icache_request_o), 32'h1);
        end
        chk_out("rdy_c6_out", 32'h0, 32'h0);
        ifc.icache_ready_i = 1'b1;
        step(3);
        chk_out("rdy_c9_out", 32'h104, ~32'h104);
        step();
        chk_out("rdy_c10_out", 32'h108, ~32'h108);

        stall_i = 1'b1;
        step(2);
        chk("stl_c12_req", 32'(ifc.icache_request_o), 32'h0);
        step();
        chk("stl_c13_req", 32'(ifc.icache_request_o), 32'h0);
        chk_out("stl_c13_out", 32'h108, ~32'h108);
        step(3);
        chk("stl_c16_req", 32'(ifc.icache_request_o), 32'h0);
        chk_out("stl_c16_out", 32'h108, ~32'h108);
        stall_i = 1'b0;
        step();
        chk("stl_c17_req", 32'(ifc.icache_request_o), 32'h1);
        chk_out("stl_c17_out", 32'h10C, ~32'h10C);
        step();
        chk_out("stl_c18_out", 32'h110, ~32'h110);
        step();
        chk_out("stl_c19_out", 32'h114, ~32'h114);
        step();
        chk_out("stl_c20_out", 32'h118, ~32'h118);
        step();
        chk_out("stl_c21_out", 32'h11C, ~32'h11C);

        reset_n = 1'b0;
        lat = 3;
        step(2);
        reset_n = 1'b1;
        #1;
        step(3);
        chk("l3_c3_addr", ifc.icache_addr_o, 32'h10C);
        restart_pc_i = 32'h2003;
        restart_i = 1'b1;
        #1;
        chk("l3_rst_req", 32'(ifc.icache_request_o), 32'h0);
        step();
        restart_i = 1'b0;
        #1;
        chk("l3_c4_req", 32'(ifc.icache_request_o), 32'h1);
        chk("l3_c4_addr", ifc.icache_addr_o, 32'h2000);
        chk_out("l3_c4_out", 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("l3_bubble", 32'h0, 32'h0);
        end
        step();
        chk_out("l3_c9_out", 32'h2000, ~32'h2000);
        step();
        chk_out("l3_c10_out", 32'h2004, ~32'h2004);
        step();
        chk_out("l3_c11_out", 32'h2008, ~32'h2008);

        reset_n = 1'b0;
        lat = 1;
        step(2);
        reset_n = 1'b1;
        #1;
        step(3);
        chk_out("wr_c3_out", 32'h100, ~32'h100);
        chk("wr_c3_dv", 32'(ifc.icache_data_valid_i), 32'h1);
        restart_pc_i = 32'hFFFFFFFF;
        restart_i = 1'b1;
        stall_i = 1'b1;
        step();
        restart_i = 1'b0;
        stall_i = 1'b0;
        #1;
        chk_out("wr_c4_out", 32'h0, 32'h0);
        chk("wr_c4_addr", ifc.icache_addr_o, 32'hFFFFFFFC);
        chk("wr_c4_req", 32'(ifc.icache_request_o), 32'h1);
        step();
        chk("wr_c5_addr", ifc.icache_addr_o, 32'h0);
        chk_out("wr_c5_out", 32'h0, 32'h0);
        step();
        chk_out("wr_c6_out", 32'h0, 32'h0);
        step();
        chk_out("wr_c7_out", 32'hFFFFFFFC, 32'h3);
        step();
        chk_out("wr_c8_out", 32'h0, 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
